// File: rtl/vj_frame_ctrl.sv
// Frame sequencer for the Viola-Jones detector: forwards one frame of UART pixels
// to the detector, buffers face boxes and returns one result packet per frame.
module vj_frame_ctrl #(
  parameter int unsigned FRAME_PIXELS  = 76800,
  parameter int unsigned MAX_FACES     = 30,
  parameter int unsigned DRAIN_TIMEOUT = 2**20
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic [7:0] pix_out_o,
  output logic       pix_start_o,
  input  logic       det_done_i,
  input  logic [7:0] det_return_i,
  input  logic       face_vld_i,
  input  logic [7:0] face_x1_i,
  input  logic [7:0] face_y1_i,
  input  logic [7:0] face_x2_i,
  input  logic [7:0] face_y2_i,
  input  logic       uart_cts_i,
  output logic       uart_rts_o,
  output logic [7:0] tx_data_o,
  output logic       tx_send_o,
  input  logic       tx_sent_i,
  output logic       busy_o
);

  localparam int unsigned PIX_W = $clog2(FRAME_PIXELS + 1);
  localparam int unsigned TMR_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam int unsigned CNT_W = 7;
  localparam int unsigned IDX_W = (MAX_FACES > 1) ? $clog2(MAX_FACES) : 1;

  typedef enum logic [2:0] {IDLE, RECV, DRAIN, TX_HDR, TX_BODY} state_e;

  state_e             state_q, state_d;
  logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [7:0]         hdr_q, hdr_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [1:0]         byte_q, byte_d;
  logic [7:0]         pix_out_q, pix_out_d;
  logic               pix_start_q, pix_start_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_send_q, tx_send_d;
  logic               rts_q, rts_d;
  logic               busy_q, busy_d;

  logic [31:0]        face_mem [MAX_FACES];
  logic               mem_we;
  logic [31:0]        mem_wdata;
  logic [31:0]        ent;
  logic [7:0]         body_byte;
  logic               final_done;

  assign mem_wdata  = {face_x1_i, face_y1_i, face_x2_i, face_y2_i};
  assign ent        = face_mem[IDX_W'(idx_q)];
  assign final_done = det_done_i && ((det_return_i == 8'h01) || (det_return_i == 8'hFF));

  // Face box storage; the valid count lives in count_q, so no reset is needed.
  always_ff @(posedge clock_i) begin
    if (mem_we) face_mem[IDX_W'(count_q)] <= mem_wdata;
  end

  // Body byte order within an entry: x1, y1, x2, y2.
  always_comb begin
    case (byte_q)
      2'd0:    body_byte = ent[31:24];
      2'd1:    body_byte = ent[23:16];
      2'd2:    body_byte = ent[15:8];
      default: body_byte = ent[7:0];
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      pix_cnt_q   <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      timer_q     <= '0;
      hdr_q       <= '0;
      idx_q       <= '0;
      byte_q      <= '0;
      pix_out_q   <= '0;
      pix_start_q <= 1'b0;
      tx_data_q   <= '0;
      tx_send_q   <= 1'b0;
      rts_q       <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      timer_q     <= timer_d;
      hdr_q       <= hdr_d;
      idx_q       <= idx_d;
      byte_q      <= byte_d;
      pix_out_q   <= pix_out_d;
      pix_start_q <= pix_start_d;
      tx_data_q   <= tx_data_d;
      tx_send_q   <= tx_send_d;
      rts_q       <= rts_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic: pixel forwarding, face capture, drain and packet transmit.
  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    timer_d     = timer_q;
    hdr_d       = hdr_q;
    idx_d       = idx_q;
    byte_d      = byte_q;
    pix_out_d   = pix_out_q;
    pix_start_d = 1'b0;
    tx_data_d   = tx_data_q;
    tx_send_d   = tx_send_q;
    mem_we      = 1'b0;

    if (((state_q == RECV) || (state_q == DRAIN)) && face_vld_i) begin
      if (count_q < CNT_W'(MAX_FACES)) begin
        mem_we  = 1'b1;
        count_d = count_q + CNT_W'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (rx_valid_i) begin
          pix_out_d   = rx_data_i;
          pix_start_d = 1'b1;
          pix_cnt_d   = PIX_W'(1);
          state_d     = RECV;
        end
      end
      RECV: begin
        if (rx_valid_i) begin
          pix_out_d   = rx_data_i;
          pix_start_d = 1'b1;
          pix_cnt_d   = pix_cnt_q + PIX_W'(1);
          if (pix_cnt_q == PIX_W'(FRAME_PIXELS - 1)) begin
            state_d = DRAIN;
            timer_d = '0;
          end
        end
      end
      DRAIN: begin
        if (final_done) begin
          hdr_d   = {ovf_d, count_d};
          state_d = TX_HDR;
        end else if (timer_q == TMR_W'(DRAIN_TIMEOUT - 1)) begin
          hdr_d   = 8'hFE;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = TX_HDR;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      TX_HDR: begin
        if (!tx_send_q) begin
          if (uart_cts_i) begin
            tx_send_d = 1'b1;
            tx_data_d = hdr_q;
          end
        end else if (tx_sent_i) begin
          tx_send_d = 1'b0;
          if (count_q == '0) begin
            ovf_d   = 1'b0;
            state_d = IDLE;
          end else begin
            idx_d   = '0;
            byte_d  = '0;
            state_d = TX_BODY;
          end
        end
      end
      TX_BODY: begin
        if (!tx_send_q) begin
          if (uart_cts_i) begin
            tx_send_d = 1'b1;
            tx_data_d = body_byte;
          end
        end else if (tx_sent_i) begin
          tx_send_d = 1'b0;
          if (byte_q == 2'd3) begin
            byte_d = '0;
            if (idx_q == count_q - CNT_W'(1)) begin
              count_d = '0;
              ovf_d   = 1'b0;
              state_d = IDLE;
            end else begin
              idx_d = idx_q + CNT_W'(1);
            end
          end else begin
            byte_d = byte_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    rts_d  = (state_d == IDLE) || (state_d == RECV);
    busy_d = (state_d != IDLE);
  end

  assign pix_out_o   = pix_out_q;
  assign pix_start_o = pix_start_q;
  assign tx_data_o   = tx_data_q;
  assign tx_send_o   = tx_send_q;
  assign uart_rts_o  = rts_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_vj_frame_ctrl.sv
// Self-checking bench for vj_frame_ctrl: table of frame scenarios, random frames
// against a packet-level model, and hand-written CTS and reset sequences.
`timescale 1ns/1ps
module tb_vj_frame_ctrl;

  localparam int unsigned FP = 16;
  localparam int unsigned MF = 2;
  localparam int unsigned DT = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] pix_out;
  logic       pix_start;
  logic       det_done;
  logic [7:0] det_return;
  logic       face_vld;
  logic [7:0] face_x1, face_y1, face_x2, face_y2;
  logic       uart_cts;
  logic       uart_rts;
  logic [7:0] tx_data;
  logic       tx_send;
  logic       tx_sent;
  logic       busy;

  always #5 clk = ~clk;

  vj_frame_ctrl #(.FRAME_PIXELS(FP), .MAX_FACES(MF), .DRAIN_TIMEOUT(DT)) dut (
    .clock_i(clk), .reset_i(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .pix_out_o(pix_out), .pix_start_o(pix_start), .det_done_i(det_done),
    .det_return_i(det_return), .face_vld_i(face_vld), .face_x1_i(face_x1),
    .face_y1_i(face_y1), .face_x2_i(face_x2), .face_y2_i(face_y2),
    .uart_cts_i(uart_cts), .uart_rts_o(uart_rts), .tx_data_o(tx_data),
    .tx_send_o(tx_send), .tx_sent_i(tx_sent), .busy_o(busy)
  );

  typedef struct {
    int         nf;
    bit         in_recv;
    bit         coinc;
    bit         bogus;
    bit         tmo;
    bit         fixed;
    int         gap;
    logic [7:0] ret;
    logic [7:0] exp_hdr;
    int         exp_len;
  } row_t;

  typedef struct {
    logic [7:0] d;
    int         c;
  } pix_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          e16 = 0;
  int          rise_cyc = 0;
  int          sent_wait = 0;
  bit          auto_tx = 1'b0;
  bit          rand_cts = 1'b0;
  bit          rand_en = 1'b0;
  bit          prev_send = 1'b0;
  bit          sent_prev = 1'b0;
  bit          cts_at_edge = 1'b0;
  logic [7:0]  prev_data = 8'h00;
  pix_t        exp_pix[$];
  logic [7:0]  got[$];
  logic [7:0]  exp_bytes[$];
  logic [31:0] cur_bx[$];
  row_t        rows[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample after the edge, check pixel forwarding and the TX handshake.
  task automatic tick();
    pix_t p;
    cts_at_edge = uart_cts;
    sent_prev   = tx_sent;
    @(posedge clk);
    #1;
    cyc++;
    rx_valid = 1'b0; face_vld = 1'b0; det_done = 1'b0; tx_sent = 1'b0;
    if (pix_start) begin
      if (exp_pix.size() == 0) chk("pix_start_spurious", 32'(pix_start), 32'd0);
      else begin
        p = exp_pix.pop_front();
        chk("pix_latency", 32'(cyc - p.c), 32'd1);
        chk("pix_data", 32'(pix_out), 32'(p.d));
      end
    end else if (exp_pix.size() > 0 && exp_pix[0].c < cyc) begin
      chk("pix_start_missing", 32'(pix_start), 32'd1);
      void'(exp_pix.pop_front());
    end
    if (tx_send && !prev_send) begin
      chk("tx_rise_needs_cts", 32'(cts_at_edge), 32'd1);
      rise_cyc = cyc;
      if (auto_tx) begin
        got.push_back(tx_data);
        sent_wait = $urandom_range(0, 4);
      end
    end
    if (prev_send && sent_prev) chk("tx_drop_after_sent", 32'(tx_send), 32'd0);
    else if (prev_send && tx_send) chk("tx_data_stable", 32'(tx_data), 32'(prev_data));
    if (auto_tx) begin
      if (tx_send && !sent_prev) begin
        if (sent_wait == 0) tx_sent = 1'b1;
        else sent_wait--;
      end else if (!tx_send && $urandom_range(0, 7) == 0) begin
        tx_sent = 1'b1;
      end
    end
    if (rand_cts) uart_cts = ($urandom_range(0, 3) != 0);
    prev_send = tx_send;
    prev_data = tx_data;
  endtask

  task automatic drive_face(input logic [31:0] b);
    face_vld = 1'b1;
    {face_x1, face_y1, face_x2, face_y2} = b;
  endtask

  // Packet model: header {ovf,count} or FE on timeout, then the first MF boxes.
  task automatic build_expect(input bit tmo);
    int n;
    exp_bytes.delete();
    if (tmo) exp_bytes.push_back(8'hFE);
    else begin
      n = (cur_bx.size() > MF) ? MF : cur_bx.size();
      exp_bytes.push_back({cur_bx.size() > MF, 7'(n)});
      for (int i = 0; i < n; i++) begin
        exp_bytes.push_back(cur_bx[i][31:24]);
        exp_bytes.push_back(cur_bx[i][23:16]);
        exp_bytes.push_back(cur_bx[i][15:8]);
        exp_bytes.push_back(cur_bx[i][7:0]);
      end
    end
  endtask

  task automatic send_frame(input row_t r);
    int npre;
    int gap;
    logic [7:0] d;
    cur_bx.delete();
    got.delete();
    rand_cts = rand_en && !r.tmo;
    uart_cts = 1'b1;
    if (r.fixed) begin
      cur_bx.push_back(32'h0A141E28);
      cur_bx.push_back(32'h323C4650);
    end else begin
      for (int j = 0; j < r.nf; j++) cur_bx.push_back($urandom);
    end
    npre = r.coinc ? r.nf - 1 : r.nf;
    for (int p = 0; p < int'(FP); p++) begin
      d = 8'($urandom_range(1, 255));
      rx_valid = 1'b1;
      rx_data  = d;
      exp_pix.push_back('{d, cyc});
      if (r.in_recv && p >= 2 && p - 2 < npre) drive_face(cur_bx[p-2]);
      tick();
      chk("rts_during_frame", 32'(uart_rts), (p == int'(FP) - 1) ? 32'd0 : 32'd1);
      if (p != int'(FP) - 1) begin
        gap = (r.gap >= 0) ? r.gap : $urandom_range(0, 3);
        repeat (gap) tick();
      end
    end
    e16 = cyc;
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    tick();
    chk("rts_drain", 32'(uart_rts), 32'd0);
    if (r.bogus) begin
      det_done = 1'b1; det_return = 8'h00; tick();
      chk("bogus_done_busy", 32'(busy), 32'd1);
    end
    if (!r.in_recv) begin
      for (int j = 0; j < npre; j++) begin
        drive_face(cur_bx[j]);
        tick();
        repeat ($urandom_range(0, 2)) tick();
      end
    end
    if (!r.tmo) begin
      det_done   = 1'b1;
      det_return = r.ret;
      if (r.coinc) drive_face(cur_bx[r.nf-1]);
      tick();
    end
    build_expect(r.tmo);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin tick(); n++; end while (busy && n < 3000);
    if (busy) chk("packet_timeout", 32'(busy), 32'd0);
  endtask

  task automatic finish_packet(input row_t r, input bit tbl);
    auto_tx = 1'b1;
    wait_idle();
    chk("pkt_len", 32'(got.size()), 32'(exp_bytes.size()));
    for (int i = 0; i < got.size() && i < exp_bytes.size(); i++)
      chk("pkt_byte", 32'(got[i]), 32'(exp_bytes[i]));
    if (tbl) begin
      chk("tbl_len", 32'(got.size()), 32'(r.exp_len));
      if (got.size() > 0) chk("tbl_hdr", 32'(got[0]), 32'(r.exp_hdr));
    end
    if (r.tmo) chk("tmo_latency", 32'(rise_cyc - e16), 32'(DT + 1));
    chk("rts_idle", 32'(uart_rts), 32'd1);
  endtask

  task automatic manual_one();
    int n = 0;
    while (!tx_send && n < 50) begin tick(); n++; end
    chk("manual_tx_wait", 32'(tx_send), 32'd1);
    tx_sent = 1'b1;
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pix_out"}, 32'(pix_out), 32'd0);
    chk({tag, "_pix_start"}, 32'(pix_start), 32'd0);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    chk({tag, "_tx_send"}, 32'(tx_send), 32'd0);
    chk({tag, "_rts"}, 32'(uart_rts), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    row_t r;
    //           nf in_r coin bog tmo fix gap ret    hdr    len
    rows[0] = '{2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2, 8'h01, 8'h02, 9};
    rows[1] = '{0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1, 8'hFF, 8'h00, 1};
    rows[2] = '{3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, 8'h01, 8'h82, 9};
    rows[3] = '{2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1, 8'hFF, 8'h02, 9};
    rows[4] = '{3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1, 8'h01, 8'h82, 9};
    rows[5] = '{1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1, 8'hFF, 8'h01, 5};
    rows[6] = '{2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, 8'h01, 8'hFE, 1};
    rows[7] = '{2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 8'h01, 8'h02, 9};

    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; det_done = 1'b0; det_return = 8'h00;
    face_vld = 1'b0; face_x1 = 8'h00; face_y1 = 8'h00; face_x2 = 8'h00; face_y2 = 8'h00;
    uart_cts = 1'b1; tx_sent = 1'b0;
    tick(); tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();
    chk("post_reset_busy", 32'(busy), 32'd0);

    // Strobes in IDLE must leave no trace.
    det_done = 1'b1; det_return = 8'h01; drive_face(32'hDEADBEEF); tx_sent = 1'b1;
    tick();
    repeat (3) tick();
    chk("idle_junk_busy", 32'(busy), 32'd0);
    chk("idle_junk_send", 32'(tx_send), 32'd0);

    rand_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_frame(rows[i]);
      finish_packet(rows[i], 1'b1);
    end

    for (int k = 0; k < 6; k++) begin
      r.nf      = $urandom_range(0, 4);
      r.in_recv = 1'($urandom_range(0, 1));
      r.coinc   = (r.nf > 0) && ($urandom_range(0, 1) == 1);
      r.bogus   = 1'($urandom_range(0, 1));
      r.tmo     = 1'b0;
      r.fixed   = 1'b0;
      r.gap     = -1;
      r.ret     = ($urandom_range(0, 1) == 1) ? 8'h01 : 8'hFF;
      r.exp_hdr = 8'h00;
      r.exp_len = 0;
      send_frame(r);
      finish_packet(r, 1'b0);
    end

    // CTS low at header, then CTS dropped while a body byte is in flight.
    rand_en = 1'b0; auto_tx = 1'b0;
    r = '{1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'h01, 8'h01, 5};
    send_frame(r);
    uart_cts = 1'b0;
    repeat (10) begin tick(); chk("cts_low_hold", 32'(tx_send), 32'd0); end
    uart_cts = 1'b1;
    tick();
    chk("cts_high_rise", 32'(tx_send), 32'd1);
    chk("cts_hdr_byte", 32'(tx_data), 32'h01);
    tx_sent = 1'b1;
    tick();
    chk("hdr_sent_drop", 32'(tx_send), 32'd0);
    tick();
    chk("body_rise", 32'(tx_send), 32'd1);
    chk("body_x1", 32'(tx_data), 32'(cur_bx[0][31:24]));
    uart_cts = 1'b0;
    repeat (5) begin
      tick();
      chk("cts_drop_hold", 32'(tx_send), 32'd1);
      chk("cts_drop_data", 32'(tx_data), 32'(cur_bx[0][31:24]));
    end
    tx_sent = 1'b1;
    tick();
    chk("body_sent_drop", 32'(tx_send), 32'd0);
    repeat (3) begin tick(); chk("cts_low_wait", 32'(tx_send), 32'd0); end
    got.delete();
    auto_tx = 1'b1;
    uart_cts = 1'b1;
    wait_idle();
    chk("cts_rest_len", 32'(got.size()), 32'd3);
    if (got.size() == 3) begin
      chk("cts_rest_y1", 32'(got[0]), 32'(cur_bx[0][23:16]));
      chk("cts_rest_x2", 32'(got[1]), 32'(cur_bx[0][15:8]));
      chk("cts_rest_y2", 32'(got[2]), 32'(cur_bx[0][7:0]));
    end

    // Reset in the middle of the body, then a fresh frame.
    auto_tx = 1'b0;
    r = '{2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'h01, 8'h02, 9};
    send_frame(r);
    manual_one();
    manual_one();
    begin
      int n = 0;
      while (!tx_send && n < 50) begin tick(); n++; end
    end
    chk("pre_reset_inflight", 32'(tx_send), 32'd1);
    rst = 1'b1;
    tick();
    chk_reset_outputs("midtx_reset");
    rst = 1'b0;
    tick();
    rand_en = 1'b1;
    r = '{1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1, 8'h01, 8'h01, 5};
    send_frame(r);
    finish_packet(r, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
